// File: rtl/ras_ctrl_if.sv
// Front-end instruction handshake into ras_ctrl.
// RAS_CTRL_COMPRESSED_EN adds the instr_is_rvc class bit.
interface ras_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             instr_valid;
    logic             instr_ready;
    logic             instr_is_call;
    logic             instr_is_ret;
    logic             instr_is_cond;
    logic [WIDTH-1:0] instr_pc;
`ifdef RAS_CTRL_COMPRESSED_EN
    logic             instr_is_rvc;

    modport master (
        output instr_valid, instr_is_call, instr_is_ret,
        output instr_is_cond, instr_pc, instr_is_rvc,
        input  instr_ready
    );
    modport slave (
        input  instr_valid, instr_is_call, instr_is_ret,
        input  instr_is_cond, instr_pc, instr_is_rvc,
        output instr_ready
    );
`else
    modport master (
        output instr_valid, instr_is_call, instr_is_ret,
        output instr_is_cond, instr_pc,
        input  instr_ready
    );
    modport slave (
        input  instr_valid, instr_is_call, instr_is_ret,
        input  instr_is_cond, instr_pc,
        output instr_ready
    );
`endif
endinterface

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: RAS commands, branch tracking, return prediction.
// Optional RAS_CTRL_COMPRESSED_EN: instr_is_rvc selects a +2 return address.
module ras_ctrl #(
    parameter int WIDTH         = 32,
    parameter int MAXBRANCHES   = 16,
    parameter int BRANCHES_ADDR = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    ras_ctrl_if.slave        instr,
    input  logic             resolve_valid,
    input  logic             resolve_mispredict,
    output logic             ras_push,
    output logic             ras_pop,
    output logic             ras_branch,
    output logic             ras_close_valid,
    output logic             ras_close_invalid,
    output logic [WIDTH-1:0] ras_din,
    input  logic [WIDTH-1:0] ras_dout,
    input  logic             ras_empty,
    output logic             pred_valid,
    output logic [WIDTH-1:0] pred_target,
    output logic             pred_empty,
    output logic             err
);
    localparam logic [BRANCHES_ADDR:0] CNT_MAX =
        (BRANCHES_ADDR+1)'(MAXBRANCHES);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   rec_hold;
    logic                   rec_hold_nxt;
    logic [BRANCHES_ADDR:0] count;
    logic                   ready;
    logic                   illegal;
    logic                   accept;
    logic                   res_ok;
    logic                   flush;
    logic [WIDTH-1:0]       ret_addr;
    logic                   pend;
    logic                   pend_empty;

    assign illegal = instr.instr_is_cond &&
                     (instr.instr_is_call || instr.instr_is_ret);
    assign accept  = instr.instr_valid && ready && !illegal;
    assign res_ok  = resolve_valid && (count != '0);
    assign flush   = res_ok && resolve_mispredict;

`ifdef RAS_CTRL_COMPRESSED_EN
    assign ret_addr = instr.instr_pc +
                      (instr.instr_is_rvc ? WIDTH'(2) : WIDTH'(4));
`else
    assign ret_addr = instr.instr_pc + WIDTH'(4);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            rec_hold <= 1'b0;
        end else begin
            state    <= state_nxt;
            rec_hold <= rec_hold_nxt;
        end
    end

    // RECOVER lasts exactly two cycles after the mispredict resolve
    always_comb begin
        state_nxt    = state;
        rec_hold_nxt = rec_hold;
        if (flush) begin
            state_nxt    = RECOVER;
            rec_hold_nxt = 1'b1;
        end else begin
            unique case (state)
                RUN: ;
                RECOVER: begin
                    if (rec_hold) rec_hold_nxt = 1'b0;
                    else          state_nxt    = RUN;
                end
            endcase
        end
    end

    always_comb begin
        ready = (state == RUN) && !resolve_valid &&
                !(instr.instr_is_cond && (count == CNT_MAX));
    end

    assign instr.instr_ready = ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ras_push          <= 1'b0;
            ras_pop           <= 1'b0;
            ras_branch        <= 1'b0;
            ras_close_valid   <= 1'b0;
            ras_close_invalid <= 1'b0;
            ras_din           <= '0;
            pend              <= 1'b0;
            pend_empty        <= 1'b0;
            count             <= '0;
            err               <= 1'b0;
        end else begin
            ras_push          <= accept && instr.instr_is_call;
            ras_pop           <= accept && instr.instr_is_ret;
            ras_branch        <= accept && instr.instr_is_cond;
            ras_close_valid   <= res_ok && !resolve_mispredict;
            ras_close_invalid <= flush;
            if (accept && instr.instr_is_call) ras_din <= ret_addr;
            pend       <= ras_pop;
            pend_empty <= ras_empty;
            if (flush)
                count <= '0;
            else if (res_ok)
                count <= count - 1'b1;
            else if (accept && instr.instr_is_cond)
                count <= count + 1'b1;
            if ((instr.instr_valid && illegal) ||
                (resolve_valid && (count == '0)))
                err <= 1'b1;
        end
    end

    // a flush in the same cycle wipes out the stale prediction
    always_comb begin
        pred_valid  = pend && !ras_close_invalid;
        pred_target = pred_valid ? ras_dout : '0;
        pred_empty  = pred_valid && pend_empty;
    end
endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl with a stack-level reference model
// and a behavioural RAS responder.
module tb_ras_ctrl;
    localparam int W  = 32;
    localparam int MB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ras_ctrl_if #(.WIDTH(W)) ifc ();

    logic         resolve_valid      = 1'b0;
    logic         resolve_mispredict = 1'b0;
    logic         ras_push, ras_pop, ras_branch;
    logic         ras_close_valid, ras_close_invalid;
    logic [W-1:0] ras_din, pred_target;
    logic [W-1:0] ras_dout  = '0;
    logic         ras_empty = 1'b1;
    logic         pred_valid, pred_empty, err;

    ras_ctrl #(.WIDTH(W), .MAXBRANCHES(MB), .BRANCHES_ADDR(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr             (ifc),
        .resolve_valid     (resolve_valid),
        .resolve_mispredict(resolve_mispredict),
        .ras_push          (ras_push),
        .ras_pop           (ras_pop),
        .ras_branch        (ras_branch),
        .ras_close_valid   (ras_close_valid),
        .ras_close_invalid (ras_close_invalid),
        .ras_din           (ras_din),
        .ras_dout          (ras_dout),
        .ras_empty         (ras_empty),
        .pred_valid        (pred_valid),
        .pred_target       (pred_target),
        .pred_empty        (pred_empty),
        .err               (err)
    );

    typedef struct {
        int cyc;
        bit push, pop, branch, cv, ci;
        logic [W-1:0] din;
    } strb_t;
    typedef struct {
        int cyc;
        bit pe;
        logic [W-1:0] pt;
    } pred_t;

    strb_t sq[$];
    pred_t pq[$];
    strb_t me;
    pred_t mpe;
    logic [W-1:0] m_stk[$];
    logic [W-1:0] r_stk[$];
    int m_cnt    = 0;
    int rec_end  = -10;
    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    bit m_err = 1'b0, exp_err = 1'b0, exp_ready = 1'b0, mon_en = 1'b0;
    bit cap_push = 1'b0, cap_pop = 1'b0, cap_rst = 1'b0;
    logic [W-1:0] cap_din = '0;
`ifdef RAS_CTRL_COMPRESSED_EN
    bit cur_rvc = 1'b0;
`endif

    int wc[3]  = '{15, 30, 35};
    int wr[3]  = '{15, 30, 35};
    int wd[3]  = '{60, 25, 10};
    int wb[3]  = '{5, 5, 10};
    int wi[3]  = '{2, 3, 3};
    int wrv[3] = '{3, 20, 15};
    int wmp[3] = '{20, 30, 30};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // RAS responder: pop before push, data valid the cycle after pop
    always @(negedge clk) begin
        cap_push = ras_push;
        cap_pop  = ras_pop;
        cap_din  = ras_din;
        cap_rst  = rst_n;
    end

    always @(posedge clk) begin
        #1;
        if (!cap_rst) begin
            r_stk.delete();
        end else begin
            if (cap_pop) begin
                if (r_stk.size() > 0) ras_dout = r_stk.pop_back();
                else                  ras_dout = $urandom;
            end
            if (cap_push) r_stk.push_back(cap_din);
        end
        ras_empty = (r_stk.size() == 0);
    end

    always @(negedge clk) begin : mon
        if (mon_en) begin
            chk("err", err, exp_err);
            if (rst_n) chk("instr_ready", ifc.instr_ready, exp_ready);
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                chk("strobe_missing", 1, 0);
                void'(sq.pop_front());
            end
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                me = sq.pop_front();
                chk("ras_push", ras_push, me.push);
                chk("ras_pop", ras_pop, me.pop);
                chk("ras_branch", ras_branch, me.branch);
                chk("ras_close_valid", ras_close_valid, me.cv);
                chk("ras_close_invalid", ras_close_invalid, me.ci);
                if (me.push) chk("ras_din", ras_din, me.din);
            end else begin
                chk("strobe_idle", {ras_push, ras_pop, ras_branch,
                    ras_close_valid, ras_close_invalid}, 0);
            end
            while (pq.size() > 0 && pq[0].cyc < cyc) begin
                chk("pred_missing", 1, 0);
                void'(pq.pop_front());
            end
            if (pq.size() > 0 && pq[0].cyc == cyc) begin
                mpe = pq.pop_front();
                chk("pred_valid", pred_valid, 1);
                chk("pred_empty", pred_empty, mpe.pe);
                if (!mpe.pe) chk("pred_target", pred_target, mpe.pt);
            end else begin
                chk("pred_idle", pred_valid, 0);
            end
        end
    end

    task automatic step(input bit v, c, r, cd, input logic [W-1:0] pc,
                        input bit rv, mp);
        strb_t e;
        pred_t p;
        bit ill, acc, rdy;
        int n;
        logic [W-1:0] ra;
        @(posedge clk);
        #1;
        n = cyc;
        ifc.instr_valid    = v;
        ifc.instr_is_call  = c;
        ifc.instr_is_ret   = r;
        ifc.instr_is_cond  = cd;
        ifc.instr_pc       = pc;
        resolve_valid      = rv;
        resolve_mispredict = mp;
`ifdef RAS_CTRL_COMPRESSED_EN
        ifc.instr_is_rvc = cur_rvc;
        ra = pc + (cur_rvc ? 32'd2 : 32'd4);
`else
        ra = pc + 32'd4;
`endif
        exp_err   = m_err;
        rdy       = (n > rec_end) && !rv && !(cd && m_cnt == MB);
        exp_ready = rdy;
        ill       = cd && (c || r);
        acc       = v && rdy && !ill;
        if (v && ill) m_err = 1'b1;
        if (rv && m_cnt == 0) m_err = 1'b1;
        e.cyc    = n + 1;
        e.push   = acc && c;
        e.pop    = acc && r;
        e.branch = acc && cd;
        e.cv     = 1'b0;
        e.ci     = 1'b0;
        e.din    = ra;
        if (acc && r) begin
            p.cyc = n + 2;
            p.pe  = (m_stk.size() == 0);
            p.pt  = '0;
            if (!p.pe) p.pt = m_stk.pop_back();
            pq.push_back(p);
        end
        if (acc && c) m_stk.push_back(ra);
        if (acc && cd) m_cnt++;
        if (rv && m_cnt > 0) begin
            if (mp) begin
                e.ci    = 1'b1;
                m_cnt   = 0;
                rec_end = n + 2;
                for (int i = pq.size() - 1; i >= 0; i--)
                    if (pq[i].cyc == n + 1) pq.delete(i);
            end else begin
                e.cv = 1'b1;
                m_cnt--;
            end
        end
        if (e.push || e.pop || e.branch || e.cv || e.ci) sq.push_back(e);
    endtask

    task automatic idle(input int k);
        repeat (k) step(0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic do_reset(input int k);
        int n;
        @(posedge clk);
        #1;
        n = cyc;
        exp_err = m_err;
        rst_n   = 1'b0;
        ifc.instr_valid = 1'b0;
        resolve_valid   = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
        rec_end = -10;
        m_stk.delete();
        for (int i = sq.size() - 1; i >= 0; i--)
            if (sq[i].cyc > n) sq.delete(i);
        for (int i = pq.size() - 1; i >= 0; i--)
            if (pq[i].cyc > n) pq.delete(i);
        repeat (k - 1) begin
            @(posedge clk);
            #1;
            exp_err = 1'b0;
        end
        @(posedge clk);
        #1;
        exp_err = 1'b0;
        rst_n   = 1'b1;
        ifc.instr_is_cond = 1'b0;
        exp_ready = 1'b1;
    endtask

    initial begin
        bit v, c, r, cd, rv, mp;
        int k, lim;
        ifc.instr_valid   = 1'b0;
        ifc.instr_is_call = 1'b0;
        ifc.instr_is_ret  = 1'b0;
        ifc.instr_is_cond = 1'b0;
        ifc.instr_pc      = '0;
`ifdef RAS_CTRL_COMPRESSED_EN
        ifc.instr_is_rvc  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {ras_push, ras_pop, ras_branch,
            ras_close_valid, ras_close_invalid}, 0);
        chk("rst_ras_din", ras_din, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_target", pred_target, 0);
        chk("rst_pred_empty", pred_empty, 0);
        chk("rst_err", err, 0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_ready = 1'b1;

        step(1, 1, 0, 0, 32'h100, 0, 0);
        idle(2);
        step(1, 0, 1, 0, 32'h500, 0, 0);
        idle(3);
        step(1, 0, 1, 0, 32'h504, 0, 0);
        idle(3);
        for (int i = 0; i < MB; i++)
            step(1, 0, 0, 1, 32'h1000 + 32'(i * 4), 0, 0);
        step(1, 0, 0, 1, 32'h2000, 0, 0);
        step(1, 1, 0, 0, 32'h300, 0, 0);
        step(0, 0, 0, 0, '0, 1, 0);
        step(1, 0, 0, 1, 32'h2004, 0, 0);
        idle(1);
        step(0, 0, 0, 0, '0, 1, 1);
        repeat (3) step(1, 1, 0, 0, 32'h400, 0, 0);
        step(0, 0, 0, 0, '0, 1, 0);
        idle(3);
        step(1, 1, 0, 1, 32'h600, 0, 0);
        idle(2);
`ifdef RAS_CTRL_COMPRESSED_EN
        cur_rvc = 1'b1;
        step(1, 1, 0, 0, 32'h200, 0, 0);
        cur_rvc = 1'b0;
        idle(2);
`endif
        do_reset(2);

        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 400; i++) begin
                v  = ($urandom_range(0, 99) < 75);
                k  = $urandom_range(0, 99);
                c  = 1'b0;
                r  = 1'b0;
                cd = 1'b0;
                lim = wc[ph];
                if (k < lim) c = 1'b1;
                else if (k < lim + wr[ph]) r = 1'b1;
                else if (k < lim + wr[ph] + wd[ph]) cd = 1'b1;
                else if (k < lim + wr[ph] + wd[ph] + wb[ph]) begin
                    c = 1'b1;
                    r = 1'b1;
                end else if (k < lim + wr[ph] + wd[ph] + wb[ph] + wi[ph]) begin
                    cd = 1'b1;
                    c  = $urandom_range(0, 1) == 1;
                    r  = !c;
                end
                rv = ($urandom_range(0, 99) < wrv[ph]);
                mp = rv && ($urandom_range(0, 99) < wmp[ph]);
`ifdef RAS_CTRL_COMPRESSED_EN
                cur_rvc = $urandom_range(0, 1) == 1;
`endif
                step(v, c, r, cd, 32'($urandom), rv, mp);
            end
            if (ph == 0) do_reset(2);
        end
        idle(5);
        @(negedge clk);
        #1;
        chk("sq_drained", sq.size(), 0);
        chk("pq_drained", pq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
